// File: rtl/lsu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : lsu                                                             |
// | Purpose  : Load/store unit for the writeback stage. Turns one load or      |
// |            store into a single request/grant data-memory transaction,      |
// |            stalls the pipeline while it is outstanding, and returns the    |
// |            lane-extracted, sign/zero-extended load result.                 |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk, reset            clock; asynchronous active-high reset              |
// |   MemReadW, MemWriteW   load / store request from writeback                |
// |   Funct3W               access type (B, H, W, BU, HU)                      |
// |   AddrW, StoreDataW     byte address and store source data                 |
// |   dmem_req/we/be/addr/wdata   request channel to data memory               |
// |   dmem_gnt              memory accepted the request                        |
// |   dmem_rvalid/rdata     load response                                      |
// |   ReadData              extended load result (held until the next load)    |
// |   LsuStall              pipeline hold                                      |
// |   LsuErr                one-cycle pulse on an illegal/misaligned access    |
// +----------------------------------------------------------------------------+
module lsu (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadW,
  input  logic        MemWriteW,
  input  logic [2:0]  Funct3W,
  input  logic [31:0] AddrW,
  input  logic [31:0] StoreDataW,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] ReadData,
  output logic        LsuStall,
  output logic        LsuErr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state;
  logic [2:0]  funct3_q;
  logic [1:0]  lane_q;

  logic        is_ld;
  logic        is_st;
  logic        op_present;
  logic        f3_ok;
  logic        aligned;
  logic        legal;
  logic [3:0]  be_nxt;
  logic [31:0] wdata_nxt;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_ext;

  // Request decode and legality of the op currently presented by writeback.
  always_comb begin
    is_ld      = MemReadW & ~MemWriteW;
    is_st      = MemWriteW & ~MemReadW;
    op_present = MemReadW | MemWriteW;

    f3_ok = 1'b0;
    case (Funct3W)
      3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
      3'b100, 3'b101:         f3_ok = is_ld;  // unsigned forms exist only for loads
      default:                f3_ok = 1'b0;
    endcase

    aligned = 1'b1;
    case (Funct3W[1:0])
      2'b01:   aligned = ~AddrW[0];
      2'b10:   aligned = (AddrW[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase

    legal = (is_ld | is_st) & f3_ok & aligned;

    be_nxt    = 4'b1111;
    wdata_nxt = StoreDataW;
    case (Funct3W[1:0])
      2'b00: begin
        be_nxt    = 4'b0001 << AddrW[1:0];
        wdata_nxt = {4{StoreDataW[7:0]}};
      end
      2'b01: begin
        be_nxt    = 4'b0011 << {AddrW[1], 1'b0};
        wdata_nxt = {2{StoreDataW[15:0]}};
      end
      default: begin
        be_nxt    = 4'b1111;
        wdata_nxt = StoreDataW;
      end
    endcase
  end

  // Load extraction uses the latched byte offset, not the live address.
  always_comb begin
    lane_byte = dmem_rdata[{lane_q, 3'b000} +: 8];
    lane_half = dmem_rdata[{lane_q[1], 4'b0000} +: 16];
    case (funct3_q)
      3'b000:  load_ext = {{24{lane_byte[7]}}, lane_byte};
      3'b001:  load_ext = {{16{lane_half[15]}}, lane_half};
      3'b100:  load_ext = {24'd0, lane_byte};
      3'b101:  load_ext = {16'd0, lane_half};
      default: load_ext = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      funct3_q   <= 3'd0;
      lane_q     <= 2'd0;
      dmem_we    <= 1'b0;
      dmem_be    <= 4'd0;
      dmem_addr  <= 32'd0;
      dmem_wdata <= 32'd0;
      ReadData   <= 32'd0;
      LsuErr     <= 1'b0;
    end else begin
      LsuErr <= 1'b0;
      case (state)
        IDLE: begin
          if (legal) begin
            funct3_q   <= Funct3W;
            lane_q     <= AddrW[1:0];
            dmem_we    <= is_st;
            dmem_be    <= be_nxt;
            dmem_addr  <= {AddrW[31:2], 2'b00};
            dmem_wdata <= wdata_nxt;
            state      <= REQ;
          end else if (op_present) begin
            LsuErr <= 1'b1;
          end
        end
        REQ: begin
          if (dmem_gnt) begin
            if (dmem_we) begin
              state <= DONE;
            end else if (dmem_rvalid) begin
              // Zero-wait memory: data returned alongside the grant.
              ReadData <= load_ext;
              state    <= DONE;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (dmem_rvalid) begin
            ReadData <= load_ext;
            state    <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign dmem_req = (state == REQ);

  // The stall must rise in the same cycle the op is seen so the pipeline
  // does not advance past it; it is forced low while reset is held.
  assign LsuStall = ~reset &
                    (((state == IDLE) & legal) | (state == REQ) | (state == WAIT));

endmodule
`default_nettype wire

// File: tb/tb_lsu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_lsu                                                          |
// | Purpose  : Self-checking bench for lsu: table of directed load/store       |
// |            vectors with hand-computed results, plus sequences for stray    |
// |            handshakes and reset in the middle of a load.                   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_lsu;

  logic        clk;
  logic        reset;
  logic        MemReadW;
  logic        MemWriteW;
  logic [2:0]  Funct3W;
  logic [31:0] AddrW;
  logic [31:0] StoreDataW;
  logic        dmem_req;
  logic        dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic [31:0] ReadData;
  logic        LsuStall;
  logic        LsuErr;

  int checks;
  int failures;

  lsu dut (
    .clk        (clk),
    .reset      (reset),
    .MemReadW   (MemReadW),
    .MemWriteW  (MemWriteW),
    .Funct3W    (Funct3W),
    .AddrW      (AddrW),
    .StoreDataW (StoreDataW),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_be    (dmem_be),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_gnt   (dmem_gnt),
    .dmem_rvalid(dmem_rvalid),
    .dmem_rdata (dmem_rdata),
    .ReadData   (ReadData),
    .LsuStall   (LsuStall),
    .LsuErr     (LsuErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    int          gnt_dly;     // REQ cycles before the grant
    int          rv_dly;      // cycles after the grant until rvalid (0 = same cycle)
    logic        exp_err;
    logic [3:0]  exp_be;
    logic [31:0] exp_daddr;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rd;
    int          exp_stalls;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] sdata,
                              input logic [31:0] rdata, input int gd, input int rv,
                              input logic err, input logic [3:0] be,
                              input logic [31:0] daddr, input logic [31:0] wdata,
                              input logic [31:0] exp_rd, input int stalls);
    vec_t v;
    v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.sdata = sdata; v.rdata = rdata;
    v.gnt_dly = gd; v.rv_dly = rv; v.exp_err = err; v.exp_be = be; v.exp_daddr = daddr;
    v.exp_wdata = wdata; v.exp_rd = exp_rd; v.exp_stalls = stalls;
    return v;
  endfunction

  // Present one op, act as memory, and check the whole transaction.
  task automatic run(input vec_t v, input int idx);
    int  stalls;
    int  reqs;
    int  errs;
    int  since_gnt;
    bit  finished;
    bit  completed;
    int  exp_reqs;
    stalls = 0; reqs = 0; errs = 0; since_gnt = -1; finished = 0; completed = 0;
    exp_reqs = v.exp_err ? 0 : v.gnt_dly + 1;
    @(negedge clk);
    MemReadW = v.rd; MemWriteW = v.wr; Funct3W = v.f3; AddrW = v.addr;
    StoreDataW = v.sdata; dmem_rdata = v.rdata;
    for (int c = 0; c < 40 && !finished; c++) begin
      if (c > 0) @(negedge clk);
      // A rejected op leaves writeback after one cycle since nothing stalls.
      if (v.exp_err && c == 1) begin MemReadW = 1'b0; MemWriteW = 1'b0; end
      dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
      #1;
      stalls += int'(LsuStall);
      errs   += int'(LsuErr);
      if (dmem_req) begin
        chk($sformatf("v%0d_be", idx), {28'd0, dmem_be}, {28'd0, v.exp_be});
        chk($sformatf("v%0d_addr", idx), dmem_addr, v.exp_daddr);
        chk($sformatf("v%0d_we", idx), {31'd0, dmem_we}, {31'd0, v.wr});
        if (v.wr) chk($sformatf("v%0d_wdata", idx), dmem_wdata, v.exp_wdata);
        if (reqs == v.gnt_dly) begin
          dmem_gnt  = 1'b1;
          since_gnt = 0;
          if (v.wr) completed = 1;
          else if (v.rv_dly == 0) begin dmem_rvalid = 1'b1; completed = 1; end
        end
        reqs++;
      end else if (since_gnt >= 0 && !completed) begin
        since_gnt++;
        if (since_gnt == v.rv_dly) begin dmem_rvalid = 1'b1; completed = 1; end
      end else if (completed && !LsuStall) begin
        finished = 1;
        MemReadW = 1'b0; MemWriteW = 1'b0;
      end
      if (v.exp_err && c == 3) finished = 1;
    end
    if (!finished) begin
      failures++;
      $display("FAIL v%0d_timeout: transaction did not complete within 40 cycles", idx);
    end
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    chk($sformatf("v%0d_stalls", idx), stalls, v.exp_stalls);
    chk($sformatf("v%0d_reqs", idx), reqs, exp_reqs);
    chk($sformatf("v%0d_errs", idx), errs, v.exp_err ? 1 : 0);
    chk($sformatf("v%0d_readdata", idx), ReadData, v.exp_rd);
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1; MemReadW = 1'b0; MemWriteW = 1'b0; Funct3W = 3'd0; AddrW = 32'd0;
    StoreDataW = 32'd0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'd0;

    //        rd wr f3      addr          sdata         rdata         gd rv err be       daddr         wdata         ReadData      stalls
    vecs[0]  = mk(1, 0, 3'b000, 32'h0000_0103, 32'h0,        32'h80FF_1122, 0, 2, 0, 4'b1000, 32'h0000_0100, 32'h0,        32'hFFFF_FF80, 4);
    vecs[1]  = mk(0, 1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 32'h0,        3, 0, 0, 4'b1100, 32'h0000_0200, 32'hABCD_ABCD, 32'hFFFF_FF80, 5);
    vecs[2]  = mk(1, 0, 3'b010, 32'h0000_0101, 32'h0,        32'h0,        0, 0, 1, 4'b0000, 32'h0,        32'h0,        32'hFFFF_FF80, 0);
    vecs[3]  = mk(1, 0, 3'b101, 32'h0000_0002, 32'h0,        32'hBEEF_0000, 0, 0, 0, 4'b1100, 32'h0000_0000, 32'h0,        32'h0000_BEEF, 2);
    vecs[4]  = mk(1, 1, 3'b010, 32'h0000_0000, 32'h0,        32'h0,        0, 0, 1, 4'b0000, 32'h0,        32'h0,        32'h0000_BEEF, 0);
    vecs[5]  = mk(0, 1, 3'b000, 32'h0000_0001, 32'h0000_00A5, 32'h0,        1, 0, 0, 4'b0010, 32'h0000_0000, 32'hA5A5_A5A5, 32'h0000_BEEF, 3);
    vecs[6]  = mk(1, 0, 3'b001, 32'h0000_0306, 32'h0,        32'h8001_7FFF, 0, 1, 0, 4'b1100, 32'h0000_0304, 32'h0,        32'hFFFF_8001, 3);
    vecs[7]  = mk(0, 1, 3'b100, 32'h0000_0010, 32'h0,        32'h0,        0, 0, 1, 4'b0000, 32'h0,        32'h0,        32'hFFFF_8001, 0);
    vecs[8]  = mk(1, 0, 3'b100, 32'h0000_0005, 32'h0,        32'h1234_F656, 2, 1, 0, 4'b0010, 32'h0000_0004, 32'h0,        32'h0000_00F6, 5);
    vecs[9]  = mk(0, 1, 3'b010, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0,        0, 0, 0, 4'b1111, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0000_00F6, 2);
    vecs[10] = mk(1, 0, 3'b011, 32'h0000_0000, 32'h0,        32'h0,        0, 0, 1, 4'b0000, 32'h0,        32'h0,        32'h0000_00F6, 0);
    vecs[11] = mk(1, 0, 3'b010, 32'h0000_1000, 32'h0,        32'hCAFE_F00D, 0, 3, 0, 4'b1111, 32'h0000_1000, 32'h0,        32'hCAFE_F00D, 5);
    vecs[12] = mk(0, 1, 3'b001, 32'h0000_0203, 32'h0,        32'h0,        0, 0, 1, 4'b0000, 32'h0,        32'h0,        32'hCAFE_F00D, 0);
    vecs[13] = mk(1, 0, 3'b001, 32'h0000_0001, 32'h0,        32'h0,        0, 0, 1, 4'b0000, 32'h0,        32'h0,        32'hCAFE_F00D, 0);
    vecs[14] = mk(1, 0, 3'b110, 32'h0000_0000, 32'h0,        32'h0,        0, 0, 1, 4'b0000, 32'h0,        32'h0,        32'hCAFE_F00D, 0);

    // Reset state, checked while reset is held and after release.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_be", {28'd0, dmem_be}, 32'd0);
    chk("rst_addr", dmem_addr, 32'd0);
    chk("rst_wdata", dmem_wdata, 32'd0);
    chk("rst_readdata", ReadData, 32'd0);
    chk("rst_stall", {31'd0, LsuStall}, 32'd0);
    chk("rst_err", {31'd0, LsuErr}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < NVEC; i++) run(vecs[i], i);

    // Stray grant/rvalid with no op pending must be ignored.
    @(negedge clk);
    dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'h1111_2222;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      chk("stray_req", {31'd0, dmem_req}, 32'd0);
      chk("stray_stall", {31'd0, LsuStall}, 32'd0);
      chk("stray_readdata", ReadData, 32'hCAFE_F00D);
    end
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;

    // Reset in WAIT aborts the load; a late rvalid must not update ReadData.
    @(negedge clk);
    MemReadW = 1'b1; MemWriteW = 1'b0; Funct3W = 3'b010; AddrW = 32'h0000_0080;
    dmem_rdata = 32'h7777_7777;
    @(negedge clk);
    #1;
    chk("abort_req_up", {31'd0, dmem_req}, 32'd1);
    dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    #1;
    chk("abort_in_wait", {30'd0, dmem_req, LsuStall}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_req", {31'd0, dmem_req}, 32'd0);
    chk("abort_stall", {31'd0, LsuStall}, 32'd0);
    chk("abort_readdata", ReadData, 32'd0);
    chk("abort_be", {28'd0, dmem_be}, 32'd0);
    MemReadW = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    dmem_rvalid = 1'b1;
    @(negedge clk);
    dmem_rvalid = 1'b0;
    #1;
    chk("late_rvalid_readdata", ReadData, 32'd0);
    chk("late_rvalid_stall", {31'd0, LsuStall}, 32'd0);
    chk("late_rvalid_req", {31'd0, dmem_req}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 clk  input  1  Single clock; all state updates on its rising edge.
REQ-002 reset  input  1  Asynchronous, active-high reset.
REQ-003 MemReadW  input  1  Writeback-stage load request.
REQ-004 MemWriteW  input  1  Writeback-stage store request.
REQ-005 Funct3W  input  3  Access type: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-006 AddrW  input  32  Byte address (the ALU result in writeback).
REQ-007 StoreDataW  input  32  Store source data (rs2 in writeback).
REQ-008 dmem_req  output  1  Data-memory request valid.
REQ-009 dmem_we  output  1  1 = store, 0 = load; valid while dmem_req=1.
REQ-010 dmem_be  output  4  Byte enables; bit i selects lane [8i+7:8i].
REQ-011 dmem_addr  output  32  Word-aligned address: AddrW[31:2], low two bits 00.
REQ-012 dmem_wdata  output  32  Lane-replicated store data.
REQ-013 dmem_gnt  input  1  Memory accepted the request this cycle.
REQ-014 dmem_rvalid  input  1  Load data is valid this cycle.
REQ-015 dmem_rdata  input  32  Raw load word.
REQ-016 ReadData  output  32  Extended load result, registered.
REQ-017 LsuStall  output  1  Hold the pipeline (drives StallF/D/E/W).
REQ-018 LsuErr  output  1  One-cycle pulse on a misaligned or illegal access.

Function
REQ-019 The FSM SHALL have four states: IDLE, REQ, WAIT, DONE.
REQ-020 IDLE, legal op present: latch address, be, wdata, we and Funct3 into registers; go to REQ; assert LsuStall combinationally in the same cycle.
REQ-021 Legal op: exactly one of MemReadW/MemWriteW is set, Funct3 is valid for the direction (stores only 000/001/010), and the access is aligned (H: AddrW[0]=0; W: AddrW[1:0]=00).
REQ-022 IDLE, illegal op (both enables set, bad Funct3, or misaligned): pulse LsuErr for one cycle; issue no request; assert no stall; stay in IDLE.
REQ-023 REQ: dmem_req=1, with dmem_we/be/addr/wdata driven from the latched registers and held stable until dmem_gnt.
REQ-024 REQ with gnt: a store goes to DONE; a load goes to WAIT, or directly to DONE if dmem_rvalid is also high that cycle (capture data).
REQ-025 WAIT: dmem_req=0; on dmem_rvalid, capture the extended data into ReadData and go to DONE.
REQ-026 DONE: LsuStall=0 for exactly one cycle so the pipeline advances; go to IDLE; accept no new op in DONE.
REQ-027 LsuStall SHALL equal (IDLE and legal op) or REQ or WAIT.
REQ-028 Byte enables:
- B: 4'b0001 << AddrW[1:0].
- H: 4'b0011 << {AddrW[1],1'b0}.
- W: 4'b1111.
REQ-029 dmem_wdata:
- B: StoreDataW[7:0] replicated x4.
- H: StoreDataW[15:0] replicated x2.
- W: StoreDataW unchanged.
REQ-030 Load extraction: select the lane by the latched addr[1:0]. B/H are sign-extended; BU/HU are zero-extended; W is passed through.
REQ-031 ReadData SHALL hold its value until the next completed load; stores never modify it.
REQ-032 dmem_rvalid outside WAIT (and outside REQ+gnt for a load) SHALL be ignored.
REQ-033 dmem_gnt outside REQ SHALL be ignored.
REQ-034 Back-to-back ops: the second op is sampled in the IDLE cycle after DONE; minimum cost is 3 cycles per op (IDLE, REQ, DONE).

Reset
REQ-035 reset=1 SHALL force the following asynchronously, including mid-transaction:
- state=IDLE
- dmem_req=0, dmem_we=0, dmem_be=0, dmem_addr=0, dmem_wdata=0
- ReadData=0, LsuStall=0, LsuErr=0
REQ-036 A transaction aborted by reset SHALL NOT update ReadData, even if rvalid arrives afterwards.

Verification
REQ-037 LB with AddrW=0x103, rdata=0x80FF1122, gnt on 1st REQ cycle, rvalid 2 cycles later -> be=1000, addr=0x100, ReadData=0xFFFFFF80, stall high 4 cycles.
REQ-038 SH with AddrW=0x202, StoreDataW=0x1234ABCD, gnt delayed 3 cycles -> req/be=1100/wdata=0xABCDABCD held stable 3 cycles, DONE follows gnt, ReadData unchanged.
REQ-039 LW with AddrW=0x101 -> LsuErr pulses one cycle, dmem_req never rises, LsuStall stays 0.
REQ-040 LHU with AddrW=0x2, gnt and rvalid in the same cycle with rdata=0xBEEF0000 -> ReadData=0x0000BEEF, WAIT skipped.
REQ-041 reset asserted in WAIT, stray rvalid asserted next -> dmem_req=0 and LsuStall=0 immediately, ReadData stays 0.
REQ-042 Both MemReadW and MemWriteW high -> LsuErr pulses one cycle, no request issued.
